program_counter: RTL and testbench
==================================

// Module: program_counter
// PURPOSE
//   28-bit instruction-address register for the 32-bit RISC core; feeds instruction memory.
//   Control unit asserts fetch to latch the current PC as the fetch address, and incpc to advance.
//   Also supports absolute jump (load) and PC-relative branch, in a fixed priority.
// PARAMETERS
//   PC_WIDTH      28          width of PC and all address ports
//   RESET_VECTOR  28'h0000000 value loaded into PC on reset
//   INC_STEP      1           increment applied by incpc (word-addressed memory)
//   RAS_DEPTH     4           return-stack entries (used only with PC_RAS_EN)
// PORTS
//   clk          in   1         single clock, rising edge
//   rst_n        in   1         reset, synchronous, active-low
//   fetch        in   1         latch current PC into fetch_addr this cycle
//   incpc        in   1         PC <= PC + INC_STEP
//   load         in   1         PC <= load_addr (absolute jump)
//   load_addr    in   PC_WIDTH  jump target
//   branch       in   1         PC <= PC + branch_off
//   branch_off   in   PC_WIDTH  two's-complement branch offset
//   call         in   1         push PC+INC_STEP, then jump to load_addr (PC_RAS_EN only)
//   ret          in   1         pop return address into PC (PC_RAS_EN only)
//   pcout        out  PC_WIDTH  current PC (registered)
//   fetch_addr   out  PC_WIDTH  address latched by last fetch
//   fetch_valid  out  1         1-cycle pulse, cycle after a fetch
//   wrapped      out  1         1-cycle pulse when an increment/branch wrapped modulo 2^PC_WIDTH
// BEHAVIOUR
//   - All state updates on posedge clk; no combinational input-to-output paths.
//   - rst_n=0 at an edge: pcout=RESET_VECTOR, fetch_addr=0, fetch_valid=0, wrapped=0,
//     RAS emptied; all other inputs ignored that cycle. Reset mid-operation aborts it.
//   - PC next-state priority: ret > call > load > branch > incpc > hold.
//   - fetch is independent of PC update: fetch_addr <= old pcout, fetch_valid <= 1 next cycle;
//     fetch & incpc together -> fetch_addr=N, pcout=N+INC_STEP.
//   - No fetch -> fetch_valid=0; fetch_addr holds.
//   - Arithmetic modulo 2^PC_WIDTH; carry/borrow out of incpc or branch -> wrapped=1 for one cycle.
//     load never sets wrapped.
//   - All control inputs low -> pcout holds indefinitely.
// CONFIGURATION
//   PC_RAS_EN defined: RAS_DEPTH-entry return-address stack.
//     call pushes PC+INC_STEP and sets PC=load_addr.
//     ret pops into PC.
//     Push when full discards oldest entry.
//     ret when empty holds PC and is otherwise ignored.
//   PC_RAS_EN undefined: no stack logic; call and ret ports present but ignored.
// TESTING
//   1. rst_n=0 one edge -> pcout=0, fetch_valid=0; release, no controls for 5 cycles -> pcout stays 0.
//   2. fetch=1,incpc=1 held 10 cycles from 0 -> pcout 1..10; fetch_addr lags by one (0..9);
//      fetch_valid=1 throughout.
//   3. pcout=28'hFFFFFFF, incpc=1 -> pcout=0, wrapped=1 for one cycle.
//   4. load=1,load_addr=28'h0000100 with incpc=1 and branch=1 -> pcout=28'h0000100;
//      next cycle branch_off=28'hFFFFFFC -> 28'h00000FC.
//   5. rst_n=0 while incpc active at pcout=28'h0000020 -> pcout=0 next edge.
//   6. PC_RAS_EN: at pcout=28'h10, call to 28'h80, then ret -> 28'h80 then 28'h11;
//      ret on empty stack -> PC unchanged.

Source files
------------

// File: rtl/program_counter_if.sv
// Control-unit <-> program-counter bundle: PC update/fetch controls in, PC and fetch address out.
// The control unit owns the master side; the program counter is the slave.
interface program_counter_if #(
    parameter int PC_WIDTH = 28
);
    logic                fetch;
    logic                incpc;
    logic                load;
    logic [PC_WIDTH-1:0] load_addr;
    logic                branch;
    logic [PC_WIDTH-1:0] branch_off;
    logic                call;
    logic                ret;
    logic [PC_WIDTH-1:0] pcout;
    logic [PC_WIDTH-1:0] fetch_addr;
    logic                fetch_valid;
    logic                wrapped;

    modport master (
        output fetch, incpc, load, load_addr, branch, branch_off, call, ret,
        input  pcout, fetch_addr, fetch_valid, wrapped
    );

    modport slave (
        input  fetch, incpc, load, load_addr, branch, branch_off, call, ret,
        output pcout, fetch_addr, fetch_valid, wrapped
    );
endinterface

// File: rtl/program_counter.sv
// Instruction-address register: priority ret > call > load > branch > incpc > hold; fetch latches old PC.
// Latency: every output registered, one cycle after the controlling edge; no backpressure (always accepts).
// Optional return-address stack enabled by defining PC_RAS_EN; otherwise call/ret are ignored.
module program_counter #(
    parameter int                  PC_WIDTH     = 28,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                  INC_STEP     = 1,
    parameter int                  RAS_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    program_counter_if.slave  bus
);

    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(INC_STEP);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic                fetch_valid_q, fetch_valid_d;
    logic                wrapped_q, wrapped_d;

    logic [PC_WIDTH-1:0] inc_sum;
    logic [PC_WIDTH-1:0] br_sum;
    logic                inc_carry;
    logic                br_carry;
    logic                br_wrap;

    logic                ras_sel;
    logic                ras_hold;
    logic [PC_WIDTH-1:0] ras_pc;

    assign {inc_carry, inc_sum} = {1'b0, pc_q} + {1'b0, STEP};
    assign {br_carry, br_sum}   = {1'b0, pc_q} + {1'b0, bus.branch_off};
    // Negative offsets normally carry out; only a missing carry means a borrow past zero.
    assign br_wrap = br_carry ^ bus.branch_off[PC_WIDTH-1];

`ifdef PC_RAS_EN
    localparam int                DW       = $clog2(RAS_DEPTH + 1);
    localparam logic [DW-1:0]     RAS_FULL = DW'(RAS_DEPTH);

    logic [PC_WIDTH-1:0] stack_q [RAS_DEPTH];
    logic [PC_WIDTH-1:0] stack_d [RAS_DEPTH];
    logic [DW-1:0]       depth_q, depth_d;

    // Entry 0 is the top; pushing shifts everything down so a full push drops the oldest.
    always_comb begin
        stack_d  = stack_q;
        depth_d  = depth_q;
        ras_sel  = 1'b0;
        ras_hold = 1'b0;
        ras_pc   = stack_q[0];
        if (bus.ret) begin
            ras_sel = 1'b1;
            if (depth_q == '0) begin
                ras_hold = 1'b1;
            end else begin
                for (int i = 0; i < RAS_DEPTH - 1; i++) begin
                    stack_d[i] = stack_q[i+1];
                end
                stack_d[RAS_DEPTH-1] = '0;
                depth_d = depth_q - DW'(1);
            end
        end else if (bus.call) begin
            ras_sel = 1'b1;
            ras_pc  = bus.load_addr;
            for (int i = RAS_DEPTH - 1; i > 0; i--) begin
                stack_d[i] = stack_q[i-1];
            end
            stack_d[0] = inc_sum;
            if (depth_q != RAS_FULL) begin
                depth_d = depth_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
            depth_q <= '0;
        end else begin
            stack_q <= stack_d;
            depth_q <= depth_d;
        end
    end
`else
    logic unused_ras;

    assign ras_sel    = 1'b0;
    assign ras_hold   = 1'b0;
    assign ras_pc     = '0;
    assign unused_ras = ^{bus.call, bus.ret, (RAS_DEPTH > 0)};
`endif

    always_comb begin
        pc_d          = pc_q;
        wrapped_d     = 1'b0;
        fetch_valid_d = bus.fetch;
        fetch_addr_d  = bus.fetch ? pc_q : fetch_addr_q;
        if (ras_sel) begin
            if (!ras_hold) begin
                pc_d = ras_pc;
            end
        end else if (bus.load) begin
            pc_d = bus.load_addr;
        end else if (bus.branch) begin
            pc_d      = br_sum;
            wrapped_d = br_wrap;
        end else if (bus.incpc) begin
            pc_d      = inc_sum;
            wrapped_d = inc_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_VECTOR;
            fetch_addr_q  <= '0;
            fetch_valid_q <= 1'b0;
            wrapped_q     <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            fetch_addr_q  <= fetch_addr_d;
            fetch_valid_q <= fetch_valid_d;
            wrapped_q     <= wrapped_d;
        end
    end

    assign bus.pcout       = pc_q;
    assign bus.fetch_addr  = fetch_addr_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.wrapped     = wrapped_q;

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: directed literal scenarios followed by randomized traffic against a queue-based model.
module tb_program_counter;

    localparam int     W   = 28;
    localparam longint MOD = 64'd1 << W;
    localparam int     RASD = 4;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    program_counter_if #(.PC_WIDTH(W)) pc_bus ();

    program_counter #(
        .PC_WIDTH    (W),
        .RESET_VECTOR(28'h0000000),
        .INC_STEP    (1),
        .RAS_DEPTH   (RASD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (pc_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit           m_valid = 1'b0;
    logic [W-1:0] m_pc;
    logic [W-1:0] m_fa;
    logic         m_fv;
    logic         m_wr;
    logic [W-1:0] m_ras[$];

    always @(posedge clk) begin
        longint s;
        logic [W-1:0] nxt;
        if (!rst_n) begin
            m_valid = 1'b1;
            m_pc    = '0;
            m_fa    = '0;
            m_fv    = 1'b0;
            m_wr    = 1'b0;
            m_ras.delete();
        end else if (m_valid) begin
            nxt  = m_pc;
            m_wr = 1'b0;
            m_fv = pc_bus.fetch;
            if (pc_bus.fetch) m_fa = m_pc;
`ifdef PC_RAS_EN
            if (pc_bus.ret) begin
                if (m_ras.size() > 0) nxt = m_ras.pop_front();
            end else if (pc_bus.call) begin
                s = (longint'(m_pc) + 1) % MOD;
                m_ras.push_front(W'(s));
                if (m_ras.size() > RASD) void'(m_ras.pop_back());
                nxt = pc_bus.load_addr;
            end else
`endif
            if (pc_bus.load) begin
                nxt = pc_bus.load_addr;
            end else if (pc_bus.branch) begin
                s    = longint'(m_pc) + longint'($signed(pc_bus.branch_off));
                m_wr = (s < 0) || (s >= MOD);
                nxt  = W'(((s % MOD) + MOD) % MOD);
            end else if (pc_bus.incpc) begin
                s    = longint'(m_pc) + 1;
                m_wr = (s >= MOD);
                nxt  = W'(s % MOD);
            end
            m_pc = nxt;
        end
    end

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_pcout", pc_bus.pcout, m_pc);
            check("model_fetch_addr", pc_bus.fetch_addr, m_fa);
            check("model_fetch_valid", W'(pc_bus.fetch_valid), W'(m_fv));
            check("model_wrapped", W'(pc_bus.wrapped), W'(m_wr));
        end
    end

    task automatic clr();
        pc_bus.fetch      = 1'b0;
        pc_bus.incpc      = 1'b0;
        pc_bus.load       = 1'b0;
        pc_bus.load_addr  = '0;
        pc_bus.branch     = 1'b0;
        pc_bus.branch_off = '0;
        pc_bus.call       = 1'b0;
        pc_bus.ret        = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_pc(input logic [W-1:0] a);
        clr();
        pc_bus.load      = 1'b1;
        pc_bus.load_addr = a;
        tick();
        clr();
    endtask

    initial begin
        rst_n = 1'b1;
        clr();
        tick();

        // Reset and idle hold
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_pcout", pc_bus.pcout, 28'h0);
        check("rst_fetch_valid", W'(pc_bus.fetch_valid), 28'h0);
        check("rst_fetch_addr", pc_bus.fetch_addr, 28'h0);
        check("rst_wrapped", W'(pc_bus.wrapped), 28'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("idle_hold", pc_bus.pcout, 28'h0);
        end

        // fetch + incpc streaming
        pc_bus.fetch = 1'b1;
        pc_bus.incpc = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("stream_pcout", pc_bus.pcout, W'(k));
            check("stream_fetch_addr", pc_bus.fetch_addr, W'(k - 1));
            check("stream_fetch_valid", W'(pc_bus.fetch_valid), 28'h1);
        end
        clr();
        tick();
        check("nofetch_valid", W'(pc_bus.fetch_valid), 28'h0);
        check("nofetch_addr_hold", pc_bus.fetch_addr, 28'h9);

        // Increment wrap at top of address space
        load_pc(28'hFFFFFFF);
        check("load_no_wrap", W'(pc_bus.wrapped), 28'h0);
        pc_bus.incpc = 1'b1;
        tick();
        check("inc_wrap_pcout", pc_bus.pcout, 28'h0);
        check("inc_wrap_flag", W'(pc_bus.wrapped), 28'h1);
        clr();
        tick();
        check("wrap_pulse_end", W'(pc_bus.wrapped), 28'h0);

        // Priority load > branch > incpc, then negative branch
        pc_bus.load       = 1'b1;
        pc_bus.load_addr  = 28'h0000100;
        pc_bus.incpc      = 1'b1;
        pc_bus.branch     = 1'b1;
        pc_bus.branch_off = 28'h0000005;
        tick();
        check("prio_load", pc_bus.pcout, 28'h0000100);
        clr();
        pc_bus.branch     = 1'b1;
        pc_bus.branch_off = 28'hFFFFFFC;
        pc_bus.incpc      = 1'b1;
        tick();
        check("branch_neg", pc_bus.pcout, 28'h00000FC);
        check("branch_neg_nowrap", W'(pc_bus.wrapped), 28'h0);
        pc_bus.branch_off = 28'hFFFFF00;
        tick();
        check("branch_borrow_pc", pc_bus.pcout, 28'hFFFFFFC);
        check("branch_borrow_flag", W'(pc_bus.wrapped), 28'h1);
        clr();

        // Reset aborts an increment in flight
        load_pc(28'h0000020);
        pc_bus.incpc = 1'b1;
        pc_bus.fetch = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clr();
        check("rst_abort_pc", pc_bus.pcout, 28'h0);
        check("rst_abort_fv", W'(pc_bus.fetch_valid), 28'h0);

        // call / ret
        load_pc(28'h0000010);
        pc_bus.call      = 1'b1;
        pc_bus.load_addr = 28'h0000080;
        tick();
        clr();
`ifdef PC_RAS_EN
        check("call_target", pc_bus.pcout, 28'h0000080);
        pc_bus.ret = 1'b1;
        tick();
        check("ret_pop", pc_bus.pcout, 28'h0000011);
        pc_bus.incpc = 1'b1;
        tick();
        check("ret_empty_hold", pc_bus.pcout, 28'h0000011);
        clr();
        // Overflow: five calls into a four-deep stack lose the first return address
        load_pc(28'h0000010);
        for (int k = 2; k <= 6; k++) begin
            pc_bus.call      = 1'b1;
            pc_bus.load_addr = W'(k * 16);
            tick();
        end
        clr();
        for (int k = 5; k >= 2; k--) begin
            pc_bus.ret = 1'b1;
            tick();
            check("ras_deep_pop", pc_bus.pcout, W'(k * 16 + 1));
        end
        tick();
        check("ras_drained_hold", pc_bus.pcout, 28'h0000021);
        clr();
`else
        check("call_ignored", pc_bus.pcout, 28'h0000010);
        pc_bus.ret = 1'b1;
        tick();
        check("ret_ignored", pc_bus.pcout, 28'h0000010);
        clr();
`endif

        // Randomized traffic, checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            int v;
            rst_n         = ($urandom_range(0, 99) != 0);
            pc_bus.fetch  = 1'($urandom_range(0, 1));
            pc_bus.incpc  = ($urandom_range(0, 3) != 0);
            pc_bus.load   = ($urandom_range(0, 7) == 0);
            pc_bus.branch = ($urandom_range(0, 3) == 0);
            pc_bus.call   = ($urandom_range(0, 7) == 0);
            pc_bus.ret    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1)
                pc_bus.load_addr = 28'hFFFFFF0 + W'($urandom_range(0, 15));
            else
                pc_bus.load_addr = W'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                v = int'($urandom_range(0, 32)) - 16;
                pc_bus.branch_off = W'(v);
            end else begin
                pc_bus.branch_off = W'($urandom);
            end
            tick();
        end
        rst_n = 1'b1;
        clr();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
